// File: rtl/seq_array_divider.sv
// seq_array_divider
//
// Sequential restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit divisor.
// It produces one quotient bit per clock. A product from the array multiplier, divided
// by either of its factors, returns the other factor with a remainder of zero.
//
// Ports:
//   clk          clock; all state updates on its rising edge
//   rst          asynchronous, active-high reset; discards any in-flight division
//   start        request; sampled only while idle
//   dividend     2*WIDTH-bit numerator, captured with an accepted start
//   divisor      WIDTH-bit denominator, captured with an accepted start
//   busy         high whenever the unit is not idle
//   done         one-cycle pulse; results are valid in this cycle
//   quotient     registered WIDTH-bit quotient
//   remainder    registered WIDTH-bit remainder
//   div_by_zero  registered flag: the divisor was zero
//   overflow     registered flag: the quotient does not fit in WIDTH bits
//
// Optional build macro:
//   DIV_UNITY_FASTPATH_EN - when defined, a divisor of 1 with a zero dividend high half
//   finishes in one cycle. When undefined, that case takes the normal iterative path.
//   The results are identical either way; only the latency differs.
//
// Latency, counting the start-accept cycle as cycle 0:
//   - normal divisions: done in cycle WIDTH+1;
//   - zero-divisor, overflow and fast paths: done in cycle 1.

module seq_array_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder R
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend low half, shifted out as quotient bits come in
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;       // captured divisor; the input may change after acceptance

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] div_hi, div_lo;
  logic [WIDTH+1:0] shifted;            // {R,Q} shifted left by one, R part only
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  assign div_hi = dividend[2*WIDTH-1:WIDTH];
  assign div_lo = dividend[WIDTH-1:0];

  // One restoring step. Because R < divisor holds invariantly, the top bit of the
  // shifted value is always zero, so the MSB of the difference is the subtractor's
  // borrow-out.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {2'b00, dvs_q};
    borrow   = diff[WIDTH+1];
    rem_next = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    quo_next = {quo_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = div_lo;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
          end else if (div_hi >= divisor) begin
            // A quotient of WIDTH bits cannot represent the result.
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = div_lo;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
`ifdef DIV_UNITY_FASTPATH_EN
          end else if (divisor == WIDTH'(1)) begin
            // The high half must be zero here; otherwise the overflow branch would have fired.
            state_d     = ST_DONE;
            quotient_d  = div_lo;
            remainder_d = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b0;
`endif
          end else begin
            state_d = ST_CALC;
            rem_d   = {1'b0, div_hi};
            quo_d   = div_lo;
            cnt_d   = CW'(WIDTH);
          end
        end
      end

      ST_CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = ST_DONE;
          quotient_d  = quo_next;
          remainder_d = rem_next[WIDTH-1:0];
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_array_divider.sv
// Directed testbench for seq_array_divider with WIDTH=4. The expected values are
// computed by hand.

module tb_seq_array_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int checks;
  int failures;

  seq_array_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive a start for one edge, then wait for done. The caller sits mid-cycle.
  // lat is the number of cycles after the accept cycle at which done was seen
  // (99 on timeout). busy_ok reports whether busy was high in every cycle up to done.
  task automatic run_div(input logic [7:0] dd, input logic [3:0] dv,
                         output int lat, output logic busy_ok);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    if (!done) lat = 99;
  endtask

  // Check the result in the done cycle, then step one cycle and check the
  // done pulse ended and the results are held.
  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [3:0] q, input logic [3:0] r,
                              input logic dbz, input logic ovf);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".q"}, quotient, q);
    check({tag, ".r"}, remainder, r);
    check({tag, ".flags"}, {div_by_zero, overflow}, {dbz, ovf});
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, {done, busy}, 2'b00);
    check({tag, ".hold"}, {quotient, remainder}, {q, r});
  endtask

  int   lat;
  logic bok;
  int   unity_lat;

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", {busy, done, quotient, remainder, div_by_zero, overflow}, 12'h000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 143 / 11 = 13 r 0
    run_div(8'h8F, 4'hB, lat, bok);
    check_result("d8F_B", lat, 5, 4'hD, 4'h0, 1'b0, 1'b0);

    // 100 / 7 = 14 r 2; busy must be high in cycles 1..5
    run_div(8'h64, 4'h7, lat, bok);
    check("d64_7.busy", bok, 1'b1);
    check_result("d64_7", lat, 5, 4'hE, 4'h2, 1'b0, 1'b0);

    // high half 0xA >= 5 -> overflow
    run_div(8'hA5, 4'h5, lat, bok);
    check_result("ovf", lat, 1, 4'hF, 4'h5, 1'b0, 1'b1);

    // divide by zero
    run_div(8'h3C, 4'h0, lat, bok);
    check_result("dbz", lat, 1, 4'hF, 4'hC, 1'b1, 1'b0);

    // maximum quotient: 159 / 10 = 15 r 9
    run_div(8'h9F, 4'hA, lat, bok);
    check_result("d9F_A", lat, 5, 4'hF, 4'h9, 1'b0, 1'b0);

    // 14 / 3 = 4 r 2
    run_div(8'h0E, 4'h3, lat, bok);
    check_result("d0E_3", lat, 5, 4'h4, 4'h2, 1'b0, 1'b0);

    // start with different operands in cycle 2 must be ignored
    start    = 1'b1;
    dividend = 8'h8F;
    divisor  = 4'hB;
    @(posedge clk);
    #1;
    start = 1'b0;                   // cycle 1
    @(posedge clk);
    #1;
    start    = 1'b1;                // cycle 2
    dividend = 8'h64;
    divisor  = 4'h7;
    @(posedge clk);
    #1;
    start = 1'b0;                   // cycle 3
    lat   = 3;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = 99;
    check("ign.lat", lat, 5);
    check("ign.qr", {quotient, remainder}, 8'hD0);
    @(posedge clk);
    #1;                             // cycle 6: idle again, a new start is accepted
    check("ign.idle", busy, 1'b0);
    run_div(8'h64, 4'h7, lat, bok);
    check_result("after_ign", lat, 5, 4'hE, 4'h2, 1'b0, 1'b0);

    // asynchronous reset mid-CALC
    start    = 1'b1;
    dividend = 8'h64;
    divisor  = 4'h7;
    @(posedge clk);
    #1;
    start = 1'b0;                   // cycle 1
    repeat (2) begin
      @(posedge clk);
      #1;
    end                             // cycle 3
    check("rst.busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst.async", {busy, done, quotient, remainder, div_by_zero, overflow}, 12'h000);
    @(posedge clk);
    #1;
    check("rst.held", {busy, done, quotient, remainder}, 10'h000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_div(8'h8F, 4'hB, lat, bok);
    check_result("post_rst", lat, 5, 4'hD, 4'h0, 1'b0, 1'b0);

    // divisor 1: latency depends on the fast-path build option
`ifdef DIV_UNITY_FASTPATH_EN
    unity_lat = 1;
`else
    unity_lat = 5;
`endif
    run_div(8'h09, 4'h1, lat, bok);
    check_result("unity", lat, unity_lat, 4'h9, 4'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
